// File: rtl/nrf24_pkg.sv
// Shared nRF24L01 definitions: SPI command opcodes and the byte-shifter FSM state encoding.
package nrf24_pkg;

    localparam logic [7:0] R_REGISTER   = 8'h00;
    localparam logic [7:0] W_REGISTER   = 8'h20;
    localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] FLUSH_TX     = 8'hE1;
    localparam logic [7:0] FLUSH_RX     = 8'hE2;
    localparam logic [7:0] NOP          = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } spi_state_e;

endpackage

// File: rtl/nrf24_spi_tick.sv
// Half-period tick for the SPI master: counts 0..HALF-1 while enabled, pulses on the last count.
module nrf24_spi_tick #(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int unsigned     CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/nrf24_spi_master.sv
// nRF24L01 SPI master, mode 0, one byte per spi_start, CSN held across bytes by spi_hold_csn.
// Optional macro NRF_SPI_CSN_GAP_EN enforces a minimum CSN-high gap and latches early starts.
module nrf24_spi_master
    import nrf24_pkg::*;
#(
    parameter int unsigned SYS_CLK_HZ     = 100_000_000,
    parameter int unsigned SPI_CLK_HZ     = 1_000_000,
    parameter int unsigned CSN_GAP_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_start,
    input  logic [7:0] spi_tx,
    input  logic       spi_hold_csn,
    output logic [7:0] spi_rx,
    output logic       spi_done,
    output logic       busy,
    output logic       SCK,
    output logic       MOSI,
    output logic       CSN,
    input  logic       MISO
);
    localparam int unsigned HALF = SYS_CLK_HZ / (2 * SPI_CLK_HZ);

    spi_state_e state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic [7:0] rx_q, rx_d;
    logic [2:0] bit_q, bit_d;
    logic       sck_q, sck_d;
    logic       csn_q, csn_d;
    logic       tick, go, hold_ok, tick_en;
    logic [7:0] launch_byte;

`ifdef NRF_SPI_CSN_GAP_EN
    localparam logic [31:0] GAP_LOAD = (CSN_GAP_CYCLES > 0) ? 32'(CSN_GAP_CYCLES - 1) : 32'd0;

    logic [31:0] gap_q, gap_d;
    logic        pend_q, pend_d;
    logic [7:0]  ptx_q, ptx_d;

    assign go          = (state_q == IDLE) && (gap_q == 32'd0) && (pend_q || spi_start);
    assign launch_byte = pend_q ? ptx_q : spi_tx;
    assign hold_ok     = (gap_q == 32'd0);
    assign busy        = (state_q != IDLE) || pend_q;

    // A start that lands inside the gap is parked until the gap has run out.
    always_comb begin
        pend_d = pend_q;
        ptx_d  = ptx_q;
        gap_d  = gap_q;
        if (go) begin
            pend_d = 1'b0;
        end else if ((state_q == IDLE) && !pend_q && spi_start) begin
            pend_d = 1'b1;
            ptx_d  = spi_tx;
        end
        if (!csn_q && csn_d) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != 32'd0) begin
            gap_d = gap_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_q  <= '0;
            pend_q <= 1'b0;
            ptx_q  <= '0;
        end else begin
            gap_q  <= gap_d;
            pend_q <= pend_d;
            ptx_q  <= ptx_d;
        end
    end
`else
    assign go          = (state_q == IDLE) && spi_start;
    assign launch_byte = spi_tx;
    assign hold_ok     = 1'b1;
    assign busy        = (state_q != IDLE);
`endif

    assign tick_en = (state_q == LEAD) || (state_q == SHIFT_HI) || (state_q == SHIFT_LO);

    nrf24_spi_tick #(
        .HALF (HALF)
    ) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (tick_en),
        .clear_i (go),
        .tick_o  (tick)
    );

    // MISO is captured on the edge that raises SCK; MOSI is tx_q[7] and advances as SCK falls.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = LEAD;
                    tx_d    = launch_byte;
                    bit_d   = 3'd0;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                    rxsh_d  = {rxsh_q[6:0], MISO};
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    state_d = SHIFT_LO;
                    tx_d    = {tx_q[6:0], 1'b0};
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = DONE;
                        rx_d    = rxsh_q;
                    end else begin
                        state_d = SHIFT_HI;
                        bit_d   = bit_q + 3'd1;
                        rxsh_d  = {rxsh_q[6:0], MISO};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sck_d = (state_d == SHIFT_HI);
        csn_d = (state_d == IDLE) && !(spi_hold_csn && hold_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
        end
    end

    assign spi_done = (state_q == DONE);
    assign spi_rx   = rx_q;
    assign SCK      = sck_q;
    assign MOSI     = tx_q[7];
    assign CSN      = csn_q;

endmodule

// File: tb/tb_nrf24_spi_master.sv
// Self-checking bench for nrf24_spi_master at H=2: table vectors, random bytes and corner sequences.
// Define NRF_SPI_CSN_GAP_EN to also exercise the CSN gap sequence.
module tb_nrf24_spi_master;
    import nrf24_pkg::*;

    localparam int SYS_HZ  = 100_000_000;
    localparam int SPI_HZ  = 25_000_000;
    localparam int H       = SYS_HZ / (2 * SPI_HZ);
    localparam int EXP_LAT = 1 + 17 * H;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_start = 1'b0;
    logic [7:0] spi_tx = 8'h00;
    logic       spi_hold_csn = 1'b0;
    logic [7:0] spi_rx;
    logic       spi_done, busy, SCK, MOSI, CSN, MISO;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         sckRises = 0, csnRises = 0, doneCount = 0, modeErr = 0, csnLowErr = 0;
    logic [7:0] mosiCap = 8'h00;
    logic [7:0] slaveByte = 8'h00;
    logic [2:0] slaveIdx = 3'd0;
    logic       sckPrev = 1'b0, csnPrev = 1'b1, mosiPrev = 1'b0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
        logic [7:0] expRx;
        logic [7:0] expMosi;
        int         expLat;
    } vec_t;

    vec_t vecs[5];

    nrf24_spi_master #(
        .SYS_CLK_HZ     (SYS_HZ),
        .SPI_CLK_HZ     (SPI_HZ),
        .CSN_GAP_CYCLES (5)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .spi_start    (spi_start),
        .spi_tx       (spi_tx),
        .spi_hold_csn (spi_hold_csn),
        .spi_rx       (spi_rx),
        .spi_done     (spi_done),
        .busy         (busy),
        .SCK          (SCK),
        .MOSI         (MOSI),
        .CSN          (CSN),
        .MISO         (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: bit7 first after CSN falls, next bit after every SCK fall.
    assign MISO = slaveByte[3'd7 - slaveIdx];

    // Bus monitor sampling 1 ns after each rising clock edge.
    always @(posedge clk) begin
        #1;
        if (SCK && !sckPrev) begin
            sckRises++;
            mosiCap = {mosiCap[6:0], MOSI};
            if (CSN) csnLowErr++;
        end
        if (!SCK && sckPrev) slaveIdx = slaveIdx + 3'd1;
        if (!CSN && csnPrev) slaveIdx = 3'd0;
        if (CSN && !csnPrev) csnRises++;
        if (SCK && (MOSI !== mosiPrev)) modeErr++;
        if (spi_done) doneCount++;
        sckPrev  = SCK;
        csnPrev  = CSN;
        mosiPrev = MOSI;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One spi_start; optionally a second start while busy (injectAt) or a reset pulse (resetAt).
    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] slave, input logic hold,
                                 input int injectAt, input int resetAt,
                                 output bit gotDone, output int latency, output logic [7:0] rxByte);
        int startCyc;
        @(negedge clk);
        slaveByte    = slave;
        spi_tx       = tx;
        spi_hold_csn = hold;
        spi_start    = 1'b1;
        startCyc     = cyc;
        gotDone      = 1'b0;
        latency      = -1;
        rxByte       = 8'h00;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            spi_start = 1'b0;
            if (k == 1) begin
                checkOutput("busy_after_start", busy, 1);
                checkOutput("csn_low_after_start", CSN, 0);
            end
            if (k == injectAt) begin
                spi_start = 1'b1;
                spi_tx    = 8'hFF;
            end
            if (k == resetAt) begin
                rstn = 1'b0;
                #1;
                checkOutput("reset_csn", CSN, 1);
                checkOutput("reset_sck", SCK, 0);
                checkOutput("reset_busy", busy, 0);
                checkOutput("reset_mosi", MOSI, 0);
                checkOutput("reset_spi_rx", spi_rx, 8'h00);
                checkOutput("reset_done", spi_done, 0);
                @(negedge clk);
                rstn = 1'b1;
                break;
            end
            if (spi_done) begin
                gotDone = 1'b1;
                latency = cyc - startCyc;
                rxByte  = spi_rx;
                break;
            end
        end
    endtask

    task automatic runByte(input string tag, input logic [7:0] tx, input logic [7:0] slave, input logic hold,
                           input logic [7:0] expRx, input logic [7:0] expMosi, input int expLat,
                           input bit releaseCsn);
        bit         got;
        int         lat;
        logic [7:0] rx;
        int         sck0, done0;
        sck0  = sckRises;
        done0 = doneCount;
        applyStimulus(tx, slave, hold, 0, 0, got, lat, rx);
        checkOutput({tag, " done"}, 32'(got), 1);
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " spi_rx"}, rx, expRx);
        checkOutput({tag, " mosi"}, mosiCap, expMosi);
        checkOutput({tag, " sck_rises"}, sckRises - sck0, 8);
        if (releaseCsn) begin
            @(negedge clk);
            checkOutput({tag, " csn_release"}, CSN, 1);
            checkOutput({tag, " busy_clear"}, busy, 0);
            checkOutput({tag, " done_count"}, doneCount - done0, 1);
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        bit         got;
        int         lat, csn0, sck0, done0;
        logic [7:0] rx, rtx, rsl;

        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 35};
        vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 35};
        vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 35};
        vecs[3] = '{8'h80, 8'h01, 8'h01, 8'h80, 35};
        vecs[4] = '{FLUSH_TX, 8'h96, 8'h96, 8'hE1, 35};

        repeat (3) @(negedge clk);
        checkOutput("init_csn", CSN, 1);
        checkOutput("init_sck", SCK, 0);
        checkOutput("init_mosi", MOSI, 0);
        checkOutput("init_busy", busy, 0);
        checkOutput("init_done", spi_done, 0);
        checkOutput("init_spi_rx", spi_rx, 8'h00);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            runByte($sformatf("vec%0d", i), vecs[i].tx, vecs[i].slave, 1'b0,
                    vecs[i].expRx, vecs[i].expMosi, vecs[i].expLat, 1'b1);
        end

        for (int i = 0; i < 10; i++) begin
            rtx = 8'($urandom_range(0, 255));
            rsl = 8'($urandom_range(0, 255));
            runByte($sformatf("rand%0d", i), rtx, rsl, 1'b0, rsl, rtx, EXP_LAT, 1'b1);
        end

        // Two-byte command with CSN held low, second start in the cycle after the first spi_done.
        csn0 = csnRises;
        sck0 = sckRises;
        runByte("hold_b0", W_REGISTER, 8'hA1, 1'b1, 8'hA1, 8'h20, EXP_LAT, 1'b0);
        runByte("hold_b1", 8'h0A, 8'h5E, 1'b1, 8'h5E, 8'h0A, EXP_LAT, 1'b0);
        spi_hold_csn = 1'b0;
        checkOutput("hold_no_csn_rise", csnRises - csn0, 0);
        checkOutput("hold_sck_pulses", sckRises - sck0, 16);
        repeat (3) @(negedge clk);
        checkOutput("hold_one_csn_rise", csnRises - csn0, 1);
        checkOutput("hold_csn_high", CSN, 1);
        repeat (8) @(negedge clk);

        // Start pulse while busy must be dropped.
        done0 = doneCount;
        applyStimulus(8'h01, 8'hC3, 1'b0, 10, 0, got, lat, rx);
        checkOutput("ignore_done", 32'(got), 1);
        checkOutput("ignore_latency", lat, EXP_LAT);
        checkOutput("ignore_mosi", mosiCap, 8'h01);
        checkOutput("ignore_spi_rx", rx, 8'hC3);
        repeat (40) @(negedge clk);
        checkOutput("ignore_done_count", doneCount - done0, 1);

        // Reset in the middle of a byte, then a clean transfer.
        done0 = doneCount;
        applyStimulus(8'h9C, 8'h11, 1'b0, 0, 12, got, lat, rx);
        checkOutput("reset_no_done_seen", 32'(got), 0);
        repeat (40) @(negedge clk);
        checkOutput("reset_done_count", doneCount - done0, 0);
        runByte("after_reset", R_RX_PAYLOAD, 8'hE7, 1'b0, 8'hE7, 8'h61, EXP_LAT, 1'b1);

`ifdef NRF_SPI_CSN_GAP_EN
        begin
            int riseCyc, fallCyc, doneCyc;
            runByte("gap_first", 8'h3C, 8'h00, 1'b0, 8'h00, 8'h3C, EXP_LAT, 1'b0);
            @(negedge clk);
            riseCyc = cyc;
            checkOutput("gap_csn_rose", CSN, 1);
            @(negedge clk);
            spi_tx    = FLUSH_RX;
            spi_start = 1'b1;
            @(negedge clk);
            spi_start = 1'b0;
            checkOutput("gap_busy_latched", busy, 1);
            fallCyc = -1;
            doneCyc = -1;
            for (int k = 0; k < TIMEOUT; k++) begin
                if (!CSN && (fallCyc < 0)) fallCyc = cyc;
                if (spi_done) begin
                    doneCyc = cyc;
                    break;
                end
                @(negedge clk);
            end
            checkOutput("gap_csn_high_cycles", fallCyc - riseCyc, 5);
            checkOutput("gap_latency_from_launch", doneCyc - (fallCyc - 1), EXP_LAT);
            checkOutput("gap_mosi", mosiCap, 8'hE2);
            repeat (8) @(negedge clk);
        end
`endif

        checkOutput("mosi_stable_while_sck_high", modeErr, 0);
        checkOutput("csn_low_at_sck_rise", csnLowErr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrf24_spi_master.md
NRF24_SPI_MASTER -- requirements
Module: nrf24_spi_master

Interface
REQ-001 SHALL have parameter SYS_CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SPI_CLK_HZ, default 1_000_000, SCK frequency; H = SYS_CLK_HZ/(2*SPI_CLK_HZ) system cycles per SCK half-period, H >= 2 required.
REQ-003 SHALL have parameter CSN_GAP_CYCLES, default 5, minimum CSN-high time (used only under REQ-021).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 spi_start  input  1  one-cycle request to shift one byte.
REQ-007 spi_tx  input  8  byte to send, sampled in the spi_start cycle.
REQ-008 spi_hold_csn  input  1  keep CSN low between bytes of a multi-byte command.
REQ-009 spi_rx  output  8  byte received, valid in the spi_done cycle and held until the next spi_done.
REQ-010 spi_done  output  1  one-cycle pulse, byte complete.
REQ-011 busy  output  1  high from spi_start acceptance through the spi_done cycle.
REQ-012 SCK, MOSI, CSN  output  1 each  nRF24L01 SPI pins; MISO  input  1.

Function
REQ-013 SPI mode 0 (CPOL=0, CPHA=0), MSB first; MOSI changes only while SCK low; MISO sampled on the SCK rising-edge cycle.
REQ-014 FSM states IDLE, LEAD, SHIFT_LO, SHIFT_HI, DONE: IDLE->LEAD on accepted spi_start; LEAD (H cycles, CSN low, MOSI = bit7)->SHIFT_HI; SHIFT_HI (H cycles, SCK=1)->SHIFT_LO; SHIFT_LO (H cycles, SCK=0, next bit on MOSI)->SHIFT_HI until 8 bits, then DONE; DONE (1 cycle, spi_done=1)->IDLE.
REQ-015 Latency: spi_done asserts exactly 1+17*H cycles after the spi_start cycle; identical for every byte, CSN already low or not.
REQ-016 CSN driven low in the cycle after spi_start acceptance; stays low while busy or spi_hold_csn=1; returns high the cycle after busy=0 and spi_hold_csn=0.
REQ-017 spi_start while busy=1 SHALL be ignored (no queuing, no state change); spi_start in the cycle after spi_done SHALL be accepted.
REQ-018 spi_start with spi_hold_csn=0 SHALL complete a single-byte transaction, CSN released after spi_done.
REQ-019 spi_hold_csn falling while busy SHALL NOT raise CSN before spi_done.

Reset
REQ-020 On rstn=0, immediately and mid-transfer: state IDLE, CSN=1, SCK=0, MOSI=0, spi_done=0, busy=0, spi_rx=8'h00, counters 0; the partial byte is discarded.

Configuration
REQ-021 With macro NRF_SPI_CSN_GAP_EN defined: after CSN rises it SHALL stay high at least CSN_GAP_CYCLES cycles; a spi_start arriving in the gap SHALL be latched (with spi_tx) and launched on the first cycle after the gap, busy=1 from the latch cycle, latency of REQ-015 counted from launch.
REQ-022 Without NRF_SPI_CSN_GAP_EN: no gap logic; spi_start accepted on any cycle busy=0, CSN may rise and fall on consecutive cycles.

Structure
REQ-023 Shared package nrf24_pkg SHALL hold nRF24 opcodes (R_REGISTER 8'h00, W_REGISTER 8'h20, R_RX_PAYLOAD 8'h61, W_TX_PAYLOAD 8'hA0, FLUSH_TX 8'hE1, FLUSH_RX 8'hE2, NOP 8'hFF) and the SPI FSM state encoding.
REQ-024 Sub-module nrf24_spi_tick SHALL generate the half-period tick (counter 0..H-1, cleared on transfer start); all else in nrf24_spi_master.

Verification (bench: SYS_CLK_HZ=100M, SPI_CLK_HZ=25M, H=2)
REQ-025 spi_start, spi_tx=8'hA5, hold=0, MISO model returns 8'h3C -> MOSI 10100101 on 8 rising edges, spi_rx=8'h3C, spi_done at cycle 35, CSN high at cycle 36.
REQ-026 hold=1, bytes 8'h20 then 8'h0A started cycle after each spi_done, hold dropped after second -> CSN continuously low across both, 16 SCK pulses, one CSN rise.
REQ-027 spi_start=1 with 8'hFF at cycle 10 of a transfer of 8'h01 -> ignored; only 8'h01 shifted, exactly one spi_done.
REQ-028 rstn pulsed low at cycle 12 of transfer -> CSN=1, SCK=0, busy=0 same cycle; no spi_done; next transfer of 8'h61 correct.
REQ-029 With NRF_SPI_CSN_GAP_EN, CSN_GAP_CYCLES=5, spi_start 1 cycle after CSN rises -> CSN stays high 5 cycles, byte launched afterwards, spi_done 35 cycles after launch.
